// File: rtl/sigsource_prog.sv
// sigsource_prog: runtime-programmable multi-lane antenna IQ selector.
// Double-buffered selection tables. Software fills the shadow bank, and the
// bank swap is committed on a frame start. The pipeline is two stages:
// stage 1 registers the samples and the table entries, stage 2 registers the
// selected bits.
module sigsource_prog #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TRATE = 30,
  parameter int unsigned LANES = 2,
  localparam int unsigned SBITS = $clog2(WIDTH),
  localparam int unsigned TBITS = $clog2(TRATE),
  localparam int unsigned LBITS = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               valid_i,
  input  logic               first_i,
  input  logic               next_i,
  input  logic               last_i,
  input  logic [TBITS-1:0]   taddr_i,
  input  logic [WIDTH-1:0]   idata_i,
  input  logic [WIDTH-1:0]   qdata_i,
  input  logic               cfg_we_i,
  input  logic [TBITS-1:0]   cfg_addr_i,
  input  logic [LBITS-1:0]   cfg_lane_i,
  input  logic [2*SBITS-1:0] cfg_data_i,
  input  logic               cfg_swap_i,
  output logic               cfg_ready_o,
  output logic               cfg_bank_o,
  output logic               valid_o,
  output logic               first_o,
  output logic               next_o,
  output logic               last_o,
  output logic [LANES-1:0]   ai_o,
  output logic [LANES-1:0]   aq_o,
  output logic [LANES-1:0]   bi_o,
  output logic [LANES-1:0]   bq_o
);

  localparam int unsigned EBITS = 2 * SBITS;
  localparam int unsigned TSPAN = 1 << TBITS;
  localparam int unsigned LSPAN = 1 << LBITS;
  localparam int unsigned ISPAN = 1 << SBITS;

  // Range checks are done as constant lookup masks, one bit per encodable
  // value. This avoids comparisons that are trivially true for power-of-two sizes.
  function automatic logic [TSPAN-1:0] taddr_mask();
    logic [TSPAN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < TSPAN; i++) m[i] = (i < TRATE);
    return m;
  endfunction

  function automatic logic [LSPAN-1:0] lane_mask();
    logic [LSPAN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LSPAN; i++) m[i] = (i < LANES);
    return m;
  endfunction

  localparam logic [TSPAN-1:0] TADDR_OK = taddr_mask();
  localparam logic [LSPAN-1:0] LANE_OK  = lane_mask();

  typedef enum logic {
    SW_IDLE,
    SW_PENDING
  } swap_state_t;

  swap_state_t      state_q, state_d;
  logic             active_bank_q;
  logic             commit;
  logic             read_bank;
  logic             wr_bank;
  logic             wr_en;
  logic             taddr_ok;

  logic [EBITS-1:0] tbl [2][TRATE][LANES];
  logic [EBITS-1:0] rd_entry [LANES];

  logic [WIDTH-1:0] s1_idata, s1_qdata;
  logic [EBITS-1:0] s1_entry [LANES];
  logic             s1_oor;
  logic             s1_valid, s1_first, s1_next, s1_last;

  logic [ISPAN-1:0] i_ext, q_ext;
  logic [LANES-1:0] sel_ai, sel_aq, sel_bi, sel_bq;

  // Swap request state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= SW_IDLE;
    else          state_q <= state_d;
  end

  // Swap request next state: arm on request, commit on a valid frame start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SW_IDLE:    if (cfg_swap_i)          state_d = SW_PENDING;
      SW_PENDING: if (valid_i && first_i)  state_d = SW_IDLE;
      default:                             state_d = SW_IDLE;
    endcase
  end

  // Swap request outputs: the config port is ready only with no swap pending.
  always_comb begin
    cfg_ready_o = (state_q == SW_IDLE);
    commit      = (state_q == SW_PENDING) && valid_i && first_i;
  end

  // Active bank flips on the commit edge.
  always_ff @(posedge clock) begin
    if (!reset_n)    active_bank_q <= 1'b0;
    else if (commit) active_bank_q <= ~active_bank_q;
  end

  assign cfg_bank_o = active_bank_q;
  assign wr_bank    = ~active_bank_q;
  // The committing sample already reads the new bank, ahead of the flip.
  assign read_bank  = active_bank_q ^ commit;
  assign taddr_ok   = TADDR_OK[taddr_i];
  assign wr_en      = cfg_we_i && cfg_ready_o && TADDR_OK[cfg_addr_i] && LANE_OK[cfg_lane_i];

  // Shadow bank write port. Table contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en) tbl[wr_bank][cfg_addr_i][cfg_lane_i] <= cfg_data_i;
  end

  // Table read for all lanes at the incoming slot address.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      rd_entry[k] = '0;
      if (taddr_ok) rd_entry[k] = tbl[read_bank][taddr_i][k];
    end
  end

  // Stage 1: samples, table entries, range flag and controls.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_idata <= '0;
      s1_qdata <= '0;
      for (int unsigned k = 0; k < LANES; k++) s1_entry[k] <= '0;
      s1_oor   <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_next  <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_idata <= idata_i;
      s1_qdata <= qdata_i;
      for (int unsigned k = 0; k < LANES; k++) s1_entry[k] <= rd_entry[k];
      s1_oor   <= ~taddr_ok;
      s1_valid <= valid_i;
      s1_first <= first_i;
      s1_next  <= next_i;
      s1_last  <= last_i;
    end
  end

  // Zero-extend the sample buses so any index >= WIDTH picks a 0 bit.
  always_comb begin
    i_ext = '0;
    q_ext = '0;
    i_ext[WIDTH-1:0] = s1_idata;
    q_ext[WIDTH-1:0] = s1_qdata;
  end

  // Per-lane bit selection. An out-of-range slot blanks all data bits.
  always_comb begin
    sel_ai = '0;
    sel_aq = '0;
    sel_bi = '0;
    sel_bq = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (!s1_oor) begin
        sel_ai[k] = i_ext[s1_entry[k][EBITS-1:SBITS]];
        sel_aq[k] = q_ext[s1_entry[k][EBITS-1:SBITS]];
        sel_bi[k] = i_ext[s1_entry[k][SBITS-1:0]];
        sel_bq[k] = q_ext[s1_entry[k][SBITS-1:0]];
      end
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      first_o <= 1'b0;
      next_o  <= 1'b0;
      last_o  <= 1'b0;
      ai_o    <= '0;
      aq_o    <= '0;
      bi_o    <= '0;
      bq_o    <= '0;
    end else begin
      valid_o <= s1_valid;
      first_o <= s1_first;
      next_o  <= s1_next;
      last_o  <= s1_last;
      ai_o    <= sel_ai;
      aq_o    <= sel_aq;
      bi_o    <= sel_bi;
      bq_o    <= sel_bq;
    end
  end

endmodule
